chunked_addsub: RTL and testbench
=================================

# chunked_addsub

Parametrised, fully pipelined WIDTH-bit adder/subtractor that splits operands into CHUNK-bit slices and ripples the carry through one slice per pipeline stage. It accepts a new operand pair every clock and returns results in order after a fixed latency. It is the general-purpose arithmetic unit for the GeneticAlgorithm datapath, including fitness accumulation and offset subtraction. It adds subtract mode, carry/borrow and signed-overflow flags, and optional saturation.

## Interface

Parameters:

- WIDTH, 48, operand/result width in bits
- CHUNK, 16, slice width per pipeline stage; WIDTH must be an integer multiple of CHUNK, CHUNK >= 2
- NCHUNK, WIDTH/CHUNK, derived (localparam), number of carry stages

Ports:

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- adder_en  input  1  operand strobe; sampled each rising edge, no backpressure
- sub  input  1  0 = operand1 + operand2, 1 = operand1 - operand2; sampled with adder_en
- operand1  input  WIDTH  first operand
- operand2  input  WIDTH  second operand
- sum  output  WIDTH  result, registered
- c_out  output  1  add: carry out of MSB; sub: borrow (1 when operand1 < operand2 unsigned)
- ovf  output  1  two's-complement signed overflow of the true result
- sum_vail  output  1  one-cycle strobe, sum/c_out/ovf valid

## Operation

- Stage 0 (input register):
  - On an edge with adder_en=1, capture operand1, the effective operand2 (~operand2 when sub=1), sub, and valid=1.
  - Otherwise set valid=0; the data registers may hold.
- Stage k, k=1..NCHUNK:
  - Add slice k-1 of both operands plus carry-in.
  - Carry-in for slice 0 is sub; for slice k>0 it is the registered carry-out of stage k-1.
  - Register the slice result, carry-out, the remaining upper slices, all already-computed lower result slices, sub, and the MSBs of both operands. Valid shifts with the data.
- Output (stage NCHUNK register) drives sum, c_out, ovf and sum_vail directly:
  - c_out = carry-out of MSB XOR sub.
  - ovf = (a_msb == b_eff_msb) AND (sum_msb != a_msb), where b_eff is operand2 after optional inversion.
- Each in-flight operation is independent. Carries never leak between consecutive operations.
- Arithmetic is modulo 2^WIDTH. Unsigned results use c_out; signed results use ovf.

## Timing

- Latency L = NCHUNK + 1 rising edges. If adder_en=1 at edge T, sum_vail=1 in the cycle after edge T+NCHUNK and results hold until the next valid result.
  - Default parameters: L = 4.
  - NCHUNK=1: L = 2.
- Throughput is one operation per clock. N consecutive adder_en cycles produce N consecutive sum_vail cycles, in order.
- Gaps in adder_en reproduce as gaps in sum_vail with identical spacing.
- sum_vail pulses for exactly one cycle per accepted operation. sum, c_out and ovf change only on cycles where sum_vail=1.
- Reset (rst_n=0, asynchronous):
  - All valid bits clear immediately.
  - sum=0, c_out=0, ovf=0, sum_vail=0.
  - In-flight operations are discarded.
  - After release, sum_vail stays 0 until L edges after the first post-reset adder_en.
- adder_en asserted in the same cycle rst_n deasserts is not guaranteed to be accepted. The first guaranteed accept is the edge after release.

## Configuration

- SATURATE_EN defined: when ovf=1, sum is clamped to the signed limit.
  - Clamp to {1'b0,{WIDTH-1{1'b1}}} if a_msb=0, else {1'b1,{WIDTH-1{1'b0}}}.
  - The clamp is applied in the final stage with no extra latency.
  - ovf and c_out still report the unclamped condition.
- SATURATE_EN undefined: sum always wraps modulo 2^WIDTH and ovf is flag only. No clamp logic is synthesised.

## Test plan

- Add, carry across chunks: 0x0000_0000_FFFF + 0x0000_0000_0001, sub=0 -> sum=0x0000_0001_0000, c_out=0, ovf=0, sum_vail exactly 4 edges after the strobe.
- Subtract with borrow: 5 - 7, sub=1 -> sum=0xFFFF_FFFF_FFFE, c_out=1, ovf=0. Then 7 - 5 -> sum=2, c_out=0.
- Signed overflow: 0x7FFF_FFFF_FFFF + 1 -> ovf=1, c_out=0.
  - Without SATURATE_EN: sum=0x8000_0000_0000.
  - With SATURATE_EN: sum=0x7FFF_FFFF_FFFF.
  - 0xFFFF_FFFF_FFFF + 1 -> sum=0, c_out=1, ovf=0.
- Streaming: 8 back-to-back random add/sub operations plus a 2-cycle gap, then 4 more -> 12 correct results in order, with sum_vail showing the same gap pattern delayed by L.
- Reset mid-flight: issue 3 operations, pull rst_n low 2 cycles later -> outputs 0 immediately, no sum_vail for the discarded operations. A post-reset operation returns a correct result after L edges.
- Parameter sweep: WIDTH=16/CHUNK=16 gives L=2; WIDTH=64/CHUNK=8 gives L=9. Check 0xFF..FF + 1 carries through every slice (sum=0, c_out=1).

Source files
------------

// File: rtl/chunked_addsub.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit slice per stage, carry rippled stage to stage.
// Define SATURATE_EN to clamp overflowing results to the signed limit (flags still report the raw result).
module chunked_addsub #(
  parameter int WIDTH = 48,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adder_en,
  input  logic             sub,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             sum_vail
);
  localparam int NCHUNK = WIDTH / CHUNK;

  logic [WIDTH-1:0] a0_reg;
  logic [WIDTH-1:0] b0_reg;
  logic             sub0_reg;
  logic             vld0_reg;

  // Subtraction is a + ~b + 1; the +1 enters as the slice-0 carry-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_reg   <= '0;
      b0_reg   <= '0;
      sub0_reg <= 1'b0;
      vld0_reg <= 1'b0;
    end else begin
      vld0_reg <= adder_en;
      if (adder_en) begin
        a0_reg   <= operand1;
        b0_reg   <= sub ? ~operand2 : operand2;
        sub0_reg <= sub;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= NCHUNK; gi++) begin : g_stage
      localparam int SRC_W = (NCHUNK - gi + 1) * CHUNK;

      logic [SRC_W-1:0]    a_src;
      logic [SRC_W-1:0]    b_src;
      logic                cin;
      logic                sub_src;
      logic                vld_src;
      logic                a_msb_src;
      logic                b_msb_src;
      logic [CHUNK:0]      slice_sum;
      logic [gi*CHUNK-1:0] res_q;
      logic                cy_q;
      logic                sub_q;
      logic                vld_q;
      logic                a_msb_q;
      logic                b_msb_q;

      if (gi == 1) begin : g_src
        assign a_src     = a0_reg;
        assign b_src     = b0_reg;
        assign cin       = sub0_reg;
        assign sub_src   = sub0_reg;
        assign vld_src   = vld0_reg;
        assign a_msb_src = a0_reg[WIDTH-1];
        assign b_msb_src = b0_reg[WIDTH-1];
      end else begin : g_src
        assign a_src     = g_stage[gi-1].g_hi.a_hi_q;
        assign b_src     = g_stage[gi-1].g_hi.b_hi_q;
        assign cin       = g_stage[gi-1].cy_q;
        assign sub_src   = g_stage[gi-1].sub_q;
        assign vld_src   = g_stage[gi-1].vld_q;
        assign a_msb_src = g_stage[gi-1].a_msb_q;
        assign b_msb_src = g_stage[gi-1].b_msb_q;
      end

      // The operand slice being consumed always sits at the bottom of a_src/b_src.
      assign slice_sum = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, cin};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cy_q    <= 1'b0;
          sub_q   <= 1'b0;
          vld_q   <= 1'b0;
          a_msb_q <= 1'b0;
          b_msb_q <= 1'b0;
        end else begin
          vld_q <= vld_src;
          if (vld_src) begin
            cy_q    <= slice_sum[CHUNK];
            sub_q   <= sub_src;
            a_msb_q <= a_msb_src;
            b_msb_q <= b_msb_src;
          end
        end
      end

      if (gi == 1) begin : g_res
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            res_q <= '0;
          end else if (vld_src) begin
            res_q <= slice_sum[CHUNK-1:0];
          end
        end
      end else begin : g_res
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            res_q <= '0;
          end else if (vld_src) begin
            res_q <= {slice_sum[CHUNK-1:0], g_stage[gi-1].res_q};
          end
        end
      end

      if (gi < NCHUNK) begin : g_hi
        logic [SRC_W-CHUNK-1:0] a_hi_q;
        logic [SRC_W-CHUNK-1:0] b_hi_q;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_hi_q <= '0;
            b_hi_q <= '0;
          end else if (vld_src) begin
            a_hi_q <= a_src[SRC_W-1:CHUNK];
            b_hi_q <= b_src[SRC_W-1:CHUNK];
          end
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] res_fin;
  logic             a_msb_fin;
  logic             b_msb_fin;

  assign res_fin   = g_stage[NCHUNK].res_q;
  assign a_msb_fin = g_stage[NCHUNK].a_msb_q;
  assign b_msb_fin = g_stage[NCHUNK].b_msb_q;
  assign sum_vail  = g_stage[NCHUNK].vld_q;
  assign c_out     = g_stage[NCHUNK].cy_q ^ g_stage[NCHUNK].sub_q;
  assign ovf       = (a_msb_fin == b_msb_fin) && (res_fin[WIDTH-1] != a_msb_fin);

`ifdef SATURATE_EN
  assign sum = ovf ? {a_msb_fin, {(WIDTH-1){~a_msb_fin}}} : res_fin;
`else
  assign sum = res_fin;
`endif

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub: default 48/16 instance plus 16/16 and 64/8 sweep instances.
module tb_chunked_addsub;
  localparam int W = 48;
  localparam int L = 4;
  localparam longint SMAX = 64'sh0000_7FFF_FFFF_FFFF;
  localparam longint SMIN = -SMAX - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         sum_vail;

  logic         en_s = 1'b0;
  logic         sub_s = 1'b0;
  logic [15:0]  a16 = '0;
  logic [15:0]  b16 = '0;
  logic [15:0]  sum16;
  logic         c16, o16, v16;
  logic [63:0]  a64 = '0;
  logic [63:0]  b64 = '0;
  logic [63:0]  sum64;
  logic         c64, o64, v64;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_c = 1'b0;
  logic         last_v = 1'b0;

  chunked_addsub u_dut (
    .clk(clk), .rst_n(rst_n), .adder_en(en), .sub(sub), .operand1(op1), .operand2(op2),
    .sum(sum), .c_out(c_out), .ovf(ovf), .sum_vail(sum_vail)
  );

  chunked_addsub #(.WIDTH(16), .CHUNK(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .adder_en(en_s), .sub(sub_s), .operand1(a16), .operand2(b16),
    .sum(sum16), .c_out(c16), .ovf(o16), .sum_vail(v16)
  );

  chunked_addsub #(.WIDTH(64), .CHUNK(8)) u_w64 (
    .clk(clk), .rst_n(rst_n), .adder_en(en_s), .sub(sub_s), .operand1(a64), .operand2(b64),
    .sum(sum64), .c_out(c64), .ovf(o64), .sum_vail(v64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: true unsigned and signed results in wider arithmetic.
  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int due);
    exp_t       e;
    longint     sa, sbv, t;
    logic [W:0] u;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    t   = s ? sa - sbv : sa + sbv;
    u   = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    e.sum = u[W-1:0];
    e.c   = u[W];
    e.v   = (t > SMAX) || (t < SMIN);
`ifdef SATURATE_EN
    if (e.v) e.sum = (t > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    e.cyc = due;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [63:0] x;
    x = {$urandom, $urandom};
    case ($urandom_range(7))
      0: x = '1;
      1: x = 64'h0000_7FFF_FFFF_FFFF;
      2: x = 64'h0000_8000_0000_0000;
      3: x = 64'(x[15:0]);
      default: ;
    endcase
    return x[W-1:0];
  endfunction

  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    en  = 1'b1;
    sub = s;
    op1 = a;
    op2 = b;
    sb.push_back(model(s, a, b, cyc + L));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("drain_outstanding", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare every result strobe against the scoreboard; outputs must hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (sum_vail) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_vail: got sum_vail=1 with nothing outstanding, required 0");
      end else begin
        e = sb.pop_front();
        check("sum", 64'(sum), 64'(e.sum));
        check("c_out", 64'(c_out), 64'(e.c));
        check("ovf", 64'(ovf), 64'(e.v));
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
        $display("result cyc=%0d sum=%h c_out=%b ovf=%b", cyc, sum, c_out, ovf);
      end
      last_sum = sum;
      last_c   = c_out;
      last_v   = ovf;
    end else begin
      check("hold", 64'({sum, c_out, ovf}), 64'({last_sum, last_c, last_v}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt16, cnt64, start;
    rst_n = 1'b0;
    #12;
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_flags", 64'({c_out, ovf, sum_vail}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 48'h0000_0000_FFFF, 48'h1);
    idle(1);
    drain();

    issue(1'b1, 48'd5, 48'd7);
    issue(1'b1, 48'd7, 48'd5);
    issue(1'b0, 48'h7FFF_FFFF_FFFF, 48'h1);
    issue(1'b0, 48'hFFFF_FFFF_FFFF, 48'h1);
    issue(1'b1, 48'h8000_0000_0000, 48'h1);
    issue(1'b1, 48'h0, 48'h8000_0000_0000);
    idle(1);
    drain();

    for (int i = 0; i < 8; i++) issue(1'($urandom_range(1)), rnd_op(), rnd_op());
    idle(2);
    for (int i = 0; i < 4; i++) issue(1'($urandom_range(1)), rnd_op(), rnd_op());
    idle(1);
    drain();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      else issue(1'($urandom_range(1)), rnd_op(), rnd_op());
    end
    idle(1);
    drain();

    // Reset while three operations are in flight; none of them may emerge.
    for (int i = 0; i < 3; i++) issue(1'b0, rnd_op(), rnd_op());
    idle(1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    last_sum = '0;
    last_c   = 1'b0;
    last_v   = 1'b0;
    #1;
    check("midreset_sum", 64'(sum), 64'd0);
    check("midreset_flags", 64'({c_out, ovf, sum_vail}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    issue(1'b1, 48'h1234_5678_9ABC, 48'h0FED_CBA9_8765);
    idle(1);
    drain();

    // Parameter sweep: all-ones + 1 must carry through every slice.
    @(negedge clk);
    en_s  = 1'b1;
    sub_s = 1'b0;
    a16   = '1;
    b16   = 16'd1;
    a64   = '1;
    b64   = 64'd1;
    start = cyc;
    cnt16 = 0;
    cnt64 = 0;
    @(negedge clk);
    en_s = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (v16) begin
        if (cnt16 == 0) begin
          check("w16_latency", 64'(cyc - start), 64'd2);
          check("w16_sum", 64'(sum16), 64'd0);
          check("w16_flags", 64'({c16, o16}), 64'b10);
        end
        cnt16++;
      end
      if (v64) begin
        if (cnt64 == 0) begin
          check("w64_latency", 64'(cyc - start), 64'd9);
          check("w64_sum", sum64, 64'd0);
          check("w64_flags", 64'({c64, o64}), 64'b10);
        end
        cnt64++;
      end
      @(negedge clk);
    end
    check("w16_pulses", 64'(cnt16), 64'd1);
    check("w64_pulses", 64'(cnt64), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
